// File: rtl/conv_pkg.sv
// Shared types and constants for the grayscale convolution datapath.
package conv_pkg;

    localparam int PIXEL_WIDTH    = 8;
    localparam int ENGINE_LATENCY = 2;

    typedef logic [2:0][2:0][PIXEL_WIDTH-1:0] win_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } conv_ctrl_state_e;

endpackage

// File: rtl/conv_window_ctrl_if.sv
// Pixel-in, window-out and result bundle between the stream source, the sequencer and the engine.
interface conv_window_ctrl_if;
    import conv_pkg::*;

    logic                   start_i;
    logic                   busy_o;
    logic                   done_o;
    logic                   pix_valid_i;
    logic                   pix_ready_o;
    logic [PIXEL_WIDTH-1:0] pix_i;
    win_t                   window_o;
    logic                   win_valid_o;
    logic                   conv_valid_i;
    logic [7:0]             conv_pixel_i;
    logic                   out_valid_o;
    logic [7:0]             out_pixel_o;

    modport master (
        input  start_i, pix_valid_i, pix_i, conv_valid_i, conv_pixel_i,
        output busy_o, done_o, pix_ready_o, window_o, win_valid_o, out_valid_o, out_pixel_o
    );

    modport slave (
        output start_i, pix_valid_i, pix_i, conv_valid_i, conv_pixel_i,
        input  busy_o, done_o, pix_ready_o, window_o, win_valid_o, out_valid_o, out_pixel_o
    );

endinterface

// File: rtl/conv_line_buffer.sv
// Two-row line buffer: lb0 holds row r-1, lb1 row r-2; read of the addressed column is combinational.
module conv_line_buffer #(
    parameter int IMG_W       = 28,
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                         clk_i,
    input  logic                         we_i,
    input  logic [$clog2(IMG_W)-1:0]     col_i,
    input  logic [PIXEL_WIDTH-1:0]       pix_i,
    output logic [1:0][PIXEL_WIDTH-1:0]  rd_o
);

    logic [PIXEL_WIDTH-1:0] lb0_q [IMG_W];
    logic [PIXEL_WIDTH-1:0] lb1_q [IMG_W];

    // Contents need no reset: rows only feed windows once two full rows have been written.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            lb1_q[col_i] <= lb0_q[col_i];
            lb0_q[col_i] <= pix_i;
        end
    end

    assign rd_o = {lb1_q[col_i], lb0_q[col_i]};

endmodule

// File: rtl/conv_window_ctrl.sv
// Raster-order 3x3 window sequencer feeding grayscale_conv and collecting its results.
// Window valid 1 cycle after pixel accept; results registered 1 cycle after the engine; no output backpressure.
module conv_window_ctrl #(
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28,
    parameter int PIXEL_WIDTH = conv_pkg::PIXEL_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    conv_window_ctrl_if.master  bus
);
    import conv_pkg::*;

    localparam int N  = (IMG_W - 2) * (IMG_H - 2);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int OW = $clog2(N + 1);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [OW-1:0] OUT_LAST = OW'(N - 1);

    conv_ctrl_state_e state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [OW-1:0]    out_cnt_q, out_cnt_d;

    logic [2:0][2:0][PIXEL_WIDTH-1:0] win_q;
    logic                             win_vld_q;
    logic                             out_vld_q;
    logic [7:0]                       out_pix_q;
    logic [1:0][PIXEL_WIDTH-1:0]      lb_rd;

    logic active;
    logic accept;

    assign active = (state_q == FILL) || (state_q == DRAIN);
    assign accept = (state_q == FILL) && bus.pix_valid_i;

    conv_line_buffer #(
        .IMG_W       (IMG_W),
        .PIXEL_WIDTH (PIXEL_WIDTH)
    ) u_line_buffer (
        .clk_i (clk_i),
        .we_i  (accept),
        .col_i (col_q),
        .pix_i (bus.pix_i),
        .rd_o  (lb_rd)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        out_cnt_d = out_cnt_q;

        if (active && bus.conv_valid_i) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end

        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d   = FILL;
                    col_d     = '0;
                    row_d     = '0;
                    out_cnt_d = '0;
                end
            end
            FILL: begin
                if (accept && (col_q == COL_LAST) && (row_q == ROW_LAST)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.conv_valid_i && (out_cnt_q == OUT_LAST)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // New column enters on the right, oldest row at index 0; left columns are stale until col >= 2.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_q     <= '0;
            win_vld_q <= 1'b0;
        end else begin
            win_vld_q <= accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= lb_rd[1];
                win_q[1][2] <= lb_rd[0];
                win_q[2][2] <= bus.pix_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_vld_q <= 1'b0;
            out_pix_q <= '0;
        end else begin
            out_vld_q <= active && bus.conv_valid_i;
            if (active && bus.conv_valid_i) begin
                out_pix_q <= bus.conv_pixel_i;
            end
        end
    end

    assign bus.busy_o      = active;
    assign bus.done_o      = (state_q == DONE);
    assign bus.pix_ready_o = (state_q == FILL);
    assign bus.window_o    = win_q;
    assign bus.win_valid_o = win_vld_q;
    assign bus.out_valid_o = out_vld_q;
    assign bus.out_pixel_o = out_pix_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl on a 4x4 frame with a behavioural centre-tap grayscale_conv.
`timescale 1ns/1ps
module tb_conv_window_ctrl;
    import conv_pkg::*;

    localparam int W = 4;
    localparam int H = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_window_ctrl_if bus();

    conv_window_ctrl #(
        .IMG_W       (W),
        .IMG_H       (H),
        .PIXEL_WIDTH (PIXEL_WIDTH)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // Engine: only the centre tap is non-zero (Q.4), result saturated to 8 bits.
    int                        kc = 16;
    logic [ENGINE_LATENCY-1:0] eng_vld = '0;
    logic [7:0]                eng_pix [ENGINE_LATENCY];

    function automatic logic [7:0] eng_eval(input win_t w, input int k);
        int acc;
        acc = (int'(w[1][1]) * k) >>> 4;
        return (acc > 255) ? 8'd255 : 8'(acc);
    endfunction

    always @(posedge clk) begin
        eng_vld    <= {eng_vld[ENGINE_LATENCY-2:0], bus.win_valid_o};
        eng_pix[0] <= eng_eval(bus.window_o, kc);
        for (int i = 1; i < ENGINE_LATENCY; i++) eng_pix[i] <= eng_pix[i-1];
    end

    assign bus.conv_valid_i = eng_vld[ENGINE_LATENCY-1];
    assign bus.conv_pixel_i = eng_pix[ENGINE_LATENCY-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] out_q  [$];
    int         winc_q [$];
    win_t       first_win;

    always @(negedge clk) begin
        if (bus.out_valid_o) out_q.push_back(bus.out_pixel_o);
        if (bus.win_valid_o) begin
            if (winc_q.size() == 0) first_win = bus.window_o;
            winc_q.push_back(cyc);
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int exp_ramp [4] = '{5, 6, 9, 10};
    int win_idx  [4] = '{10, 11, 14, 15};

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},      int'(bus.busy_o), 0);
        check({tag, "_done"},      int'(bus.done_o), 0);
        check({tag, "_ready"},     int'(bus.pix_ready_o), 0);
        check({tag, "_win_valid"}, int'(bus.win_valid_o), 0);
        check({tag, "_out_valid"}, int'(bus.out_valid_o), 0);
    endtask

    task automatic run_frame(input int mode, input bit bubble, input bit hold_start,
                             input bit check_idle, input string nm);
        int acc_cyc [16];
        int i, guard, ready_lo;
        bit phase, got_done;
        out_q.delete();
        winc_q.delete();
        @(posedge clk); #1;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = hold_start;
        i = 0; guard = 0; ready_lo = 0; phase = 1'b0;
        while (i < 16 && guard < 100) begin
            bus.pix_valid_i = !(bubble && phase);
            bus.pix_i       = (mode == 0) ? 8'(i) : 8'd200;
            @(negedge clk);
            if (!bus.pix_ready_o) ready_lo++;
            else if (bus.pix_valid_i) begin
                acc_cyc[i] = cyc;
                i++;
            end
            @(posedge clk); #1;
            phase = !phase;
            guard++;
        end
        bus.pix_valid_i = 1'b0;
        bus.start_i     = 1'b0;
        check({nm, "_accepted"}, i, 16);
        check({nm, "_ready_in_fill"}, ready_lo, 0);

        got_done = 1'b0;
        for (int k = 0; k < 30 && !got_done; k++) begin
            @(negedge clk);
            if (bus.done_o) begin
                got_done = 1'b1;
                check({nm, "_done_latency"}, cyc - acc_cyc[15], 4);
                check({nm, "_done_with_out"}, int'(bus.out_valid_o), 1);
            end
        end
        check({nm, "_done_seen"}, int'(got_done), 1);
        #1;
        check({nm, "_out_count"}, out_q.size(), 4);
        for (int j = 0; j < 4 && j < out_q.size(); j++)
            check({nm, "_out_pixel"}, int'(out_q[j]), (mode == 0) ? exp_ramp[j] : 255);
        check({nm, "_win_count"}, winc_q.size(), 4);
        for (int j = 0; j < 4 && j < winc_q.size(); j++)
            check({nm, "_win_cycle"}, winc_q[j], acc_cyc[win_idx[j]] + 1);
        if (check_idle) begin
            @(negedge clk);
            check_quiet({nm, "_idle_after"});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.start_i     = 1'b0;
        bus.pix_valid_i = 1'b0;
        bus.pix_i       = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        check("reset_out_pixel", int'(bus.out_pixel_o), 0);
        check("reset_window_zero", int'(bus.window_o != '0), 0);
        #1;
        rst_n = 1'b1;

        // Pixels offered in IDLE must be refused.
        @(posedge clk); #1;
        bus.pix_valid_i = 1'b1;
        bus.pix_i       = 8'hAA;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready", int'(bus.pix_ready_o), 0);
            check("idle_busy",  int'(bus.busy_o), 0);
        end
        @(posedge clk); #1;
        bus.pix_valid_i = 1'b0;

        run_frame(0, 1'b0, 1'b0, 1'b1, "ramp");
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                check("first_window", int'(first_win[r][c]), 4 * r + c);

        run_frame(0, 1'b1, 1'b0, 1'b1, "bubble");
        run_frame(0, 1'b0, 1'b1, 1'b1, "hold_start");
        run_frame(0, 1'b0, 1'b0, 1'b0, "b2b_a");
        run_frame(0, 1'b0, 1'b0, 1'b1, "b2b_b");

        kc = 32;
        run_frame(1, 1'b0, 1'b0, 1'b1, "sat");
        kc = 16;

        // Reset after pixel 11 with two windows in flight.
        out_q.delete();
        @(posedge clk); #1;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        for (int p = 0; p < 12; p++) begin
            bus.pix_valid_i = 1'b1;
            bus.pix_i       = 8'(p);
            @(posedge clk); #1;
        end
        bus.pix_valid_i = 1'b0;
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_quiet("mid_reset");
            check("mid_reset_window_zero", int'(bus.window_o != '0), 0);
            check("mid_reset_out_pixel", int'(bus.out_pixel_o), 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("post_reset_out_valid", int'(bus.out_valid_o), 0);
        end
        #1;
        check("post_reset_no_out", out_q.size(), 0);

        run_frame(0, 1'b0, 1'b0, 1'b1, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
